// File: rtl/p_game_mailbox.sv
`timescale 1ns/1ps
// p_game_mailbox: posts gravity-tick and key commands to the processor through the
// game mailbox registers, one at a time. It waits for an ack tagged with the command's
// sequence number and then returns the result to game logic, or abandons the command
// after a timeout.
//
// state  | meaning
// -------+-----------------------------------------------------------------
// S_IDLE | nothing outstanding; a pending tick or queued key launches a post
// S_POST | command frame first visible on data_from_game; timer cleared
// S_WAIT | frame held; waiting for an ack tagged with seq, or for the timeout

module p_game_mailbox #(
  parameter int KEY_DEPTH = 4,
  parameter int TIMEOUT   = 4096
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        tick,
  input  logic        key_valid,
  input  logic [3:0]  key_code,
  input  logic [31:0] data_to_game,
  output logic [31:0] data_from_game,
  output logic        resp_valid,
  output logic [3:0]  resp_cmd,
  output logic [23:0] resp_data,
  output logic        timeout,
  output logic        key_overflow,
  output logic        busy
);

  localparam int PW    = $clog2(KEY_DEPTH);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int TLAST = TIMEOUT - 1;

  localparam logic [PW:0]   FIFO_FULL_CNT = KEY_DEPTH[PW:0];
  localparam logic [TW-1:0] TIMER_LAST    = TLAST[TW-1:0];
  localparam logic [3:0]    CMD_TICK      = 4'h1;
  localparam logic [3:0]    CMD_KEY       = 4'h2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_POST = 2'd1,
    S_WAIT = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nxt;

  logic [7:0]    seq;
  logic [7:0]    seq_adv;
  logic [3:0]    cmd_q;
  logic [3:0]    key_q;
  logic [TW-1:0] timer;
  logic          tick_pend;

  logic [3:0]    fifo_mem [KEY_DEPTH];
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] wr_ptr;
  logic [PW:0]   count;
  logic          fifo_empty;
  logic          fifo_full;

  logic          pop;
  logic          push;
  logic          drop;
  logic          bypass;
  logic          post_tick;
  logic          post_key;
  logic [3:0]    post_code;
  logic          ack_hit;
  logic          timer_done;
  logic          fin_ack;
  logic          fin_to;

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FIFO_FULL_CNT);
  assign ack_hit    = (data_to_game[31:24] == seq);
  assign timer_done = (timer == TIMER_LAST);

  // Sequence 0 is reserved so that a cleared data_to_game can never look like an ack.
  assign seq_adv = (seq == 8'hFF) ? 8'h01 : seq + 8'h01;

  // A key that is posted straight from key_code (bypass) never enters the FIFO.
  // A pop in the same cycle frees a slot, so a full FIFO still accepts the key.
  assign push = key_valid & ~bypass & (~fifo_full | pop);
  assign drop = key_valid & ~bypass & fifo_full & ~pop;

  assign data_from_game = (state != S_IDLE) ? {seq, 15'b0, key_q, cmd_q, 1'b1} : 32'h0;
  assign busy           = (state != S_IDLE);

  // Next-state and launch decisions; tick has priority over keys.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    bypass    = 1'b0;
    post_tick = 1'b0;
    post_key  = 1'b0;
    post_code = 4'h0;
    fin_ack   = 1'b0;
    fin_to    = 1'b0;
    case (state)
      S_IDLE: begin
        if (tick_pend || tick) begin
          post_tick = 1'b1;
          state_nxt = S_POST;
        end else if (!fifo_empty) begin
          pop       = 1'b1;
          post_key  = 1'b1;
          post_code = fifo_mem[rd_ptr];
          state_nxt = S_POST;
        end else if (key_valid) begin
          bypass    = 1'b1;
          post_key  = 1'b1;
          post_code = key_code;
          state_nxt = S_POST;
        end
      end
      S_POST: begin
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (ack_hit) begin
          fin_ack   = 1'b1;
          state_nxt = S_IDLE;
        end else if (timer_done) begin
          fin_to    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // FSM state, command latch, sequence, timer and the registered response pulses.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      seq          <= 8'h01;
      cmd_q        <= 4'h0;
      key_q        <= 4'h0;
      timer        <= '0;
      tick_pend    <= 1'b0;
      resp_valid   <= 1'b0;
      resp_cmd     <= 4'h0;
      resp_data    <= 24'h0;
      timeout      <= 1'b0;
      key_overflow <= 1'b0;
    end else begin
      state        <= state_nxt;
      resp_valid   <= fin_ack;
      timeout      <= fin_to;
      key_overflow <= drop;

      if (post_tick) begin
        cmd_q <= CMD_TICK;
        key_q <= 4'h0;
      end else if (post_key) begin
        cmd_q <= CMD_KEY;
        key_q <= post_code;
      end

      // A tick that arrives while one is being posted merges into that post.
      if (post_tick) begin
        tick_pend <= 1'b0;
      end else if (tick) begin
        tick_pend <= 1'b1;
      end

      if (state == S_POST) begin
        timer <= '0;
      end else if (state == S_WAIT) begin
        timer <= timer + 1'b1;
      end

      if (fin_ack) begin
        resp_cmd  <= cmd_q;
        resp_data <= data_to_game[23:0];
      end

      if (fin_ack || fin_to) begin
        seq <= seq_adv;
      end
    end
  end

  // Key FIFO pointers and occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Key FIFO storage; contents are don't-care until written.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr] <= key_code;
    end
  end

endmodule

// File: tb/tb_p_game_mailbox.sv
`timescale 1ns/1ps
// Directed bench for p_game_mailbox with hand-computed expected frames and responses.
module tb_p_game_mailbox;

  localparam int TIMEOUT = 4096;

  logic        clock;
  logic        reset;
  logic        tick;
  logic        key_valid;
  logic [3:0]  key_code;
  logic [31:0] data_to_game;
  logic [31:0] data_from_game;
  logic        resp_valid;
  logic [3:0]  resp_cmd;
  logic [23:0] resp_data;
  logic        timeout;
  logic        key_overflow;
  logic        busy;

  int          checks = 0;
  int          errors = 0;
  logic [7:0]  exp_seq;

  logic [3:0]  codes  [5] = '{4'h1, 4'h2, 4'h3, 4'h4, 4'h6};
  logic [31:0] frames [4] = '{32'h0600_0025, 32'h0700_0045, 32'h0800_0065, 32'h0900_0085};

  p_game_mailbox #(.KEY_DEPTH(4), .TIMEOUT(TIMEOUT)) dut (
    .clock          (clock),
    .reset          (reset),
    .tick           (tick),
    .key_valid      (key_valid),
    .key_code       (key_code),
    .data_to_game   (data_to_game),
    .data_from_game (data_from_game),
    .resp_valid     (resp_valid),
    .resp_cmd       (resp_cmd),
    .resp_data      (resp_data),
    .timeout        (timeout),
    .key_overflow   (key_overflow),
    .busy           (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [7:0] next_seq(input logic [7:0] s);
    return (s == 8'hFF) ? 8'h01 : s + 8'h01;
  endfunction

  function automatic logic [31:0] frame(input logic [7:0] s, input logic [3:0] k, input logic [3:0] c);
    return {s, 15'b0, k, c, 1'b1};
  endfunction

  task automatic wait_post(input string tag);
    int n = 0;
    while (data_from_game[0] !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    if (data_from_game[0] !== 1'b1) check({tag, "_nopost"}, {31'b0, data_from_game[0]}, 32'h1);
  endtask

  // Waits for a post, checks the frame, acks it with the expected seq and checks the response.
  task automatic run_cmd(input string tag, input logic [31:0] exp_dfg, input logic [23:0] res,
                         input logic [3:0] exp_cmd);
    wait_post(tag);
    check({tag, "_dfg"}, data_from_game, exp_dfg);
    step();
    data_to_game = {exp_dfg[31:24], res};
    step();
    data_to_game = 32'h0;
    check({tag, "_rv"}, {31'b0, resp_valid}, 32'h1);
    check({tag, "_rcmd"}, {28'b0, resp_cmd}, {28'b0, exp_cmd});
    check({tag, "_rdata"}, {8'b0, resp_data}, {8'b0, res});
    check({tag, "_idle"}, data_from_game, 32'h0);
    exp_seq = next_seq(exp_seq);
  endtask

  initial begin
    #(1_000_000);
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int ov;
    int n;
    int bad;

    reset        = 1'b1;
    tick         = 1'b0;
    key_valid    = 1'b0;
    key_code     = 4'h0;
    data_to_game = 32'h0;
    exp_seq      = 8'h01;
    repeat (3) step();

    check("rst_dfg",  data_from_game, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rv",   {31'b0, resp_valid}, 32'h0);
    check("rst_rdat", {8'b0, resp_data}, 32'h0);
    check("rst_to",   {31'b0, timeout}, 32'h0);
    check("rst_ovf",  {31'b0, key_overflow}, 32'h0);

    // Tick -> TICK frame with seq 1, acked with result AB.
    reset = 1'b0;
    step();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t1_post", data_from_game, 32'h0100_0003);
    check("t1_busy", {31'b0, busy}, 32'h1);
    step();
    check("t1_hold", data_from_game, 32'h0100_0003);
    data_to_game = 32'h0100_00AB;
    step();
    data_to_game = 32'h0;
    check("t1_rv",    {31'b0, resp_valid}, 32'h1);
    check("t1_rcmd",  {28'b0, resp_cmd}, 32'h1);
    check("t1_rdata", {8'b0, resp_data}, 32'h0000_00AB);
    check("t1_dfg0",  data_from_game, 32'h0);
    step();
    check("t1_rv_pulse", {31'b0, resp_valid}, 32'h0);
    check("t1_rdata_held", {8'b0, resp_data}, 32'h0000_00AB);
    exp_seq = 8'h02;

    // Key 3 with seq 2; stale ack (seq 1) ignored, then real ack.
    key_valid = 1'b1;
    key_code  = 4'h3;
    step();
    key_valid = 1'b0;
    check("t2_post", data_from_game, 32'h0200_0065);
    step();
    data_to_game = 32'h0100_0011;
    bad = 0;
    repeat (3) begin
      step();
      if (resp_valid !== 1'b0) bad++;
    end
    check("t2_stale_rv", bad, 0);
    check("t2_busy", {31'b0, busy}, 32'h1);
    data_to_game = 32'h0200_0022;
    step();
    data_to_game = 32'h0;
    check("t2_rv",    {31'b0, resp_valid}, 32'h1);
    check("t2_rcmd",  {28'b0, resp_cmd}, 32'h2);
    check("t2_rdata", {8'b0, resp_data}, 32'h0000_0022);
    exp_seq = 8'h03;

    // Tick and key together: TICK first, KEY after its ack, then nothing left.
    tick      = 1'b1;
    key_valid = 1'b1;
    key_code  = 4'h5;
    step();
    tick      = 1'b0;
    key_valid = 1'b0;
    run_cmd("t3_tick", 32'h0300_0003, 24'h000333, 4'h1);
    run_cmd("t3_key",  32'h0400_00A5, 24'h000444, 4'h2);
    repeat (4) step();
    check("t3_empty_busy", {31'b0, busy}, 32'h0);
    check("t3_empty_dfg", data_from_game, 32'h0);

    // Five keys during WAIT into a 4-deep FIFO: one overflow, first four posted in order.
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t4_post", data_from_game, 32'h0500_0003);
    step();
    ov = 0;
    for (int i = 0; i < 5; i++) begin
      key_valid = 1'b1;
      key_code  = codes[i];
      step();
      if (key_overflow === 1'b1) ov++;
    end
    key_valid = 1'b0;
    repeat (3) begin
      step();
      if (key_overflow === 1'b1) ov++;
    end
    check("t4_ovf_count", ov, 1);
    data_to_game = 32'h0500_0055;
    step();
    data_to_game = 32'h0;
    check("t4_rv",   {31'b0, resp_valid}, 32'h1);
    check("t4_rcmd", {28'b0, resp_cmd}, 32'h1);
    exp_seq = 8'h06;
    for (int i = 0; i < 4; i++) begin
      run_cmd("t4_key", frames[i], 24'h000100 + 24'(i), 4'h2);
    end
    repeat (4) step();
    check("t4_drained", {31'b0, busy}, 32'h0);

    // No ack: timeout exactly TIMEOUT cycles after entering WAIT; late old-seq ack ignored.
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t5_post", data_from_game, 32'h0A00_0003);
    step();
    n = 0;
    while (timeout !== 1'b1 && n < TIMEOUT + 10) begin
      step();
      n++;
    end
    check("t5_to_cycles", n, TIMEOUT);
    check("t5_dfg0",  data_from_game, 32'h0);
    check("t5_busy",  {31'b0, busy}, 32'h0);
    check("t5_rv",    {31'b0, resp_valid}, 32'h0);
    check("t5_rdata", {8'b0, resp_data}, 32'h0000_0103);
    step();
    check("t5_to_pulse", {31'b0, timeout}, 32'h0);
    exp_seq = 8'h0B;
    data_to_game = 32'h0A00_0099;
    tick = 1'b1;
    step();
    tick = 1'b0;
    check("t5_next_post", data_from_game, 32'h0B00_0003);
    bad = 0;
    repeat (4) begin
      step();
      if (resp_valid !== 1'b0) bad++;
    end
    check("t5_late_ack", bad, 0);
    check("t5_still_busy", {31'b0, busy}, 32'h1);
    data_to_game = 32'h0B00_00BB;
    step();
    data_to_game = 32'h0;
    check("t5_rv",     {31'b0, resp_valid}, 32'h1);
    check("t5_rdata2", {8'b0, resp_data}, 32'h0000_00BB);
    exp_seq = 8'h0C;

    // 255 acked commands: sequence wraps FF -> 01 and never uses 0.
    for (int i = 0; i < 255; i++) begin
      tick = 1'b1;
      step();
      tick = 1'b0;
      run_cmd("t6_wrap", frame(exp_seq, 4'h0, 4'h1), i[23:0], 4'h1);
    end
    check("t6_seq_model", {24'b0, exp_seq}, 32'h0000_000C);

    // Reset mid-WAIT with a key and a tick queued: everything discarded, no pulses.
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    key_valid = 1'b1;
    key_code  = 4'h7;
    tick      = 1'b1;
    step();
    key_valid = 1'b0;
    tick      = 1'b0;
    reset     = 1'b1;
    step();
    check("r_dfg",  data_from_game, 32'h0);
    check("r_busy", {31'b0, busy}, 32'h0);
    check("r_rv",   {31'b0, resp_valid}, 32'h0);
    check("r_to",   {31'b0, timeout}, 32'h0);
    reset = 1'b0;
    bad = 0;
    repeat (5) begin
      step();
      if (busy !== 1'b0 || resp_valid !== 1'b0 || timeout !== 1'b0) bad++;
    end
    check("r_quiet", bad, 0);
    exp_seq = 8'h01;
    tick = 1'b1;
    step();
    tick = 1'b0;
    run_cmd("r_post", 32'h0100_0003, 24'h00ABCD, 4'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
